// File: rtl/freq_counter_if.sv
// freq_counter_if: symbol-stream and histogram bus of the Huffman frequency counter.
//   Stream side (master drives): start, sym_valid, sym[3:0], sym_last.
//   Result side (slave drives):  busy, sort_begin, sym_err, sat, total[15:0],
//                                node0..node9[12:0] = {count[7:0], id[4:0]}.
interface freq_counter_if;
  logic        start;
  logic        sym_valid;
  logic [3:0]  sym;
  logic        sym_last;
  logic        busy;
  logic        sort_begin;
  logic        sym_err;
  logic        sat;
  logic [15:0] total;
  logic [12:0] node0, node1, node2, node3, node4;
  logic [12:0] node5, node6, node7, node8, node9;

  modport master (
    output start, sym_valid, sym, sym_last,
    input  busy, sort_begin, sym_err, sat, total,
    input  node0, node1, node2, node3, node4, node5, node6, node7, node8, node9
  );

  modport slave (
    input  start, sym_valid, sym, sym_last,
    output busy, sort_begin, sym_err, sat, total,
    output node0, node1, node2, node3, node4, node5, node6, node7, node8, node9
  );
endinterface

// File: rtl/freq_counter.sv
// freq_counter: counts occurrences of symbols 0..9 in a stream and, at end of
// stream, holds ten {count, id} nodes with sort_begin raised for the sorter.
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - freq_counter_if.slave (stream inputs, status and node outputs)
// NUM_SYM and CNT_W are fixed at 10 and 8 by the node format.
module freq_counter #(
  parameter int          NUM_SYM = 10,
  parameter int          CNT_W   = 8,
  parameter logic [15:0] MAX_LEN = 16'd65535
) (
  input  logic          CLK,
  input  logic          nRST,
  freq_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       SYM_LIMIT = 4'(NUM_SYM);

  state_t           state_r, state_nx;
  logic [CNT_W-1:0] cnt_r  [NUM_SYM];
  logic [CNT_W-1:0] cnt_nx [NUM_SYM];
  logic [15:0]      total_r, total_nx, total_inc_s;
  logic             sym_err_r, sym_err_nx;
  logic             sat_r, sat_nx;
  logic             busy_r, sort_begin_r;

  // Next-state and next-datapath logic; start wins over everything in any state.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    total_nx    = total_r;
    sym_err_nx  = sym_err_r;
    sat_nx      = sat_r;
    total_inc_s = total_r + 16'd1;
    if (bus.start) begin
      for (int k = 0; k < NUM_SYM; k++) begin
        cnt_nx[k] = CNT_ZERO;
      end
      total_nx   = 16'd0;
      sym_err_nx = 1'b0;
      sat_nx     = 1'b0;
      state_nx   = COUNT;
    end else begin
      case (state_r)
        IDLE: state_nx = IDLE;
        COUNT: begin
          if (bus.sym_valid) begin
            if (bus.sym < SYM_LIMIT) begin
              for (int k = 0; k < NUM_SYM; k++) begin
                if (bus.sym == 4'(k)) begin
                  // Saturating bin: a full bin stays full and flags sat.
                  if (cnt_r[k] == CNT_MAX) begin
                    sat_nx = 1'b1;
                  end else begin
                    cnt_nx[k] = cnt_r[k] + CNT_ONE;
                  end
                end else begin
                  cnt_nx[k] = cnt_r[k];
                end
              end
              total_nx = total_inc_s;
              // Hitting the length limit closes the stream like sym_last.
              if (bus.sym_last || (total_inc_s == MAX_LEN)) begin
                state_nx = HOLD;
              end else begin
                state_nx = COUNT;
              end
            end else begin
              // Illegal symbol: not counted, but its sym_last still ends the stream.
              sym_err_nx = 1'b1;
              if (bus.sym_last) begin
                state_nx = HOLD;
              end else begin
                state_nx = COUNT;
              end
            end
          end else begin
            state_nx = COUNT;
          end
        end
        HOLD:    state_nx = HOLD;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, histogram and status registers; busy/sort_begin decode the next state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      for (int k = 0; k < NUM_SYM; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
      total_r      <= 16'd0;
      sym_err_r    <= 1'b0;
      sat_r        <= 1'b0;
      busy_r       <= 1'b0;
      sort_begin_r <= 1'b0;
    end else begin
      state_r      <= state_nx;
      cnt_r        <= cnt_nx;
      total_r      <= total_nx;
      sym_err_r    <= sym_err_nx;
      sat_r        <= sat_nx;
      busy_r       <= (state_nx == COUNT);
      sort_begin_r <= (state_nx == HOLD);
    end
  end

  assign bus.busy       = busy_r;
  assign bus.sort_begin = sort_begin_r;
  assign bus.sym_err    = sym_err_r;
  assign bus.sat        = sat_r;
  assign bus.total      = total_r;
  assign bus.node0      = {cnt_r[0], 5'd0};
  assign bus.node1      = {cnt_r[1], 5'd1};
  assign bus.node2      = {cnt_r[2], 5'd2};
  assign bus.node3      = {cnt_r[3], 5'd3};
  assign bus.node4      = {cnt_r[4], 5'd4};
  assign bus.node5      = {cnt_r[5], 5'd5};
  assign bus.node6      = {cnt_r[6], 5'd6};
  assign bus.node7      = {cnt_r[7], 5'd7};
  assign bus.node8      = {cnt_r[8], 5'd8};
  assign bus.node9      = {cnt_r[9], 5'd9};

endmodule

// File: doc/freq_counter.md
Name: freq_counter

Overview:
- Upstream stage of the Huffman sorter. Counts occurrences of 10 symbols (0..9) in an input symbol stream.
- On end of stream, presents ten 13-bit nodes {count[7:0], id[4:0]} and raises sort_begin for the sorting stage.
- Node k always carries id k. The sorter orders nodes by bits [12:5].

Parameters:
- NUM_SYM, 10, number of symbol bins. Fixed by the downstream node port count; only 10 is supported.
- CNT_W, 8, per-symbol count width. Equals node bits [12:5]; only 8 is supported.
- MAX_LEN, 16'd65535, stream length limit. Reaching it ends the stream as if sym_last were asserted.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request: clear all counts and begin a new stream.
- sym_valid  in  1  qualifies sym and sym_last.
- sym  in  4  symbol value; legal range 0..9.
- sym_last  in  1  marks the final symbol of the stream; meaningful only when sym_valid=1.
- busy  out  1  high while in COUNT.
- sort_begin  out  1  level; high while the nodes hold a finished histogram.
- sym_err  out  1  sticky; at least one symbol >= 10 was received in this stream.
- sat  out  1  sticky; at least one count saturated at 255 in this stream.
- total  out  16  number of symbols counted in this stream.
- node0..node9  out  13 each  node k = {cnt[k][7:0], 5'dk}.

Behaviour:
- Reset (asynchronous, nRST=0):
  - state=IDLE; all cnt=0; total=0.
  - busy=0, sort_begin=0, sym_err=0, sat=0.
  - nodes read {8'd0, id}.
- States: IDLE, COUNT, HOLD. All outputs are registered; no combinational input-to-output path.
- IDLE:
  - start=1 → next cycle: all cnt=0, total=0, sym_err=0, sat=0; state=COUNT, busy=1.
  - sym_valid is ignored in IDLE.
- COUNT, sym_valid=1, sym<10:
  - cnt[sym] increments next edge. If it is already 255 it holds at 255 and sat sets.
  - total increments.
- COUNT, sym_valid=1, sym>=10:
  - Symbol is not counted; total is unchanged; sym_err sets.
  - sym_last is still honoured.
- COUNT, end of stream:
  - sym_valid=1 with sym_last=1 → that symbol is counted first, then state=HOLD.
  - Same transition when total reaches MAX_LEN after an increment.
  - On entering HOLD: busy=0 and sort_begin=1 in the same cycle.
  - Latency: final symbol sampled at edge N → sort_begin=1 and nodes final after edge N.
- HOLD:
  - Nodes, total and flags stay frozen; sort_begin stays 1; sym_valid is ignored.
  - start=1 → next cycle: sort_begin=0, counters cleared, state=COUNT.
- start during COUNT: restarts the stream. start takes priority over a simultaneous sym_valid, which is discarded; state stays COUNT.
- Count widths: cnt is 8-bit saturating; total is 16-bit and cannot exceed MAX_LEN.
- An empty stream is not possible; the minimum stream is one symbol.
- Reset mid-stream returns immediately to IDLE with all values cleared.

Test Plan:
- Reset, then start, then stream 3,3,7,0,3(last) → sort_begin=1 one cycle after last. node3=13'h0063 ({8'd3,5'd3}), node7={8'd1,5'd7}, node0={8'd1,5'd0}, others count 0, total=5, busy=0.
- Stream 300×sym 5 then sym 1 last → node5 count=255, sat=1, node1 count=1, total=301.
- Stream containing sym 12 and sym 15 among 4 legal symbols → sym_err=1, total=4, no bin changes for illegal values.
- In HOLD, toggle sym_valid → nodes unchanged. start → sort_begin=0 next cycle, all counts 0, busy=1.
- start asserted with sym_valid=1 sym=2 mid-stream → all counts 0 afterwards, node2 count=0.
- nRST pulsed low between edges mid-stream → busy=0 and counts 0 immediately, without waiting for a clock edge. Run again with MAX_LEN=4: after 4 symbols with no sym_last → sort_begin=1.
